// File: rtl/debounce_ctrl.sv
// debounce_ctrl: multi-channel push-button debouncer driven by one shared
// slow sample tick. The long-press detector is built only when the macro
// LONG_PRESS_EN is defined; otherwise btn_long is tied low.

// One channel: 2-flop synchronizer, debounce FSM and registered pulses.
module debounce_lane #(
    parameter int STABLE_CNT = 3
`ifdef LONG_PRESS_EN
    , parameter int LONG_TICKS = 64
`endif
) (
    input  logic clk,
    input  logic clr,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic press,
    output logic press_nxt,
    output logic rls,
    output logic lng
);
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    localparam logic [3:0] STABLE = 4'(STABLE_CNT);

    logic [1:0] sync;
    logic       s;
    state_t     st, st_n;
    logic [3:0] cnt, cnt_n;
    logic       lvl_n, rls_nxt;

    assign s = sync[1];

    // Two-stage synchronizer for the asynchronous button input.
    always_ff @(posedge clk) begin
        if (clr) sync <= '0;
        else     sync <= {sync[0], raw};
    end

    // FSM state, stable count, debounced level and edge pulses.
    always_ff @(posedge clk) begin
        if (clr) begin
            st    <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rls   <= 1'b0;
        end else begin
            st    <= st_n;
            cnt   <= cnt_n;
            level <= lvl_n;
            press <= press_nxt;
            rls   <= rls_nxt;
        end
    end

    // Next state: only moves on tick cycles, otherwise holds state and count.
    always_comb begin
        st_n      = st;
        cnt_n     = cnt;
        lvl_n     = level;
        press_nxt = 1'b0;
        rls_nxt   = 1'b0;
        if (tick) begin
            case (st)
                IDLE: if (s) begin
                    st_n  = PRESS_WAIT;
                    cnt_n = 4'd1;
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        st_n  = IDLE;
                        cnt_n = '0;
                    end else if (cnt + 4'd1 == STABLE) begin
                        st_n      = PRESSED;
                        cnt_n     = '0;
                        lvl_n     = 1'b1;
                        press_nxt = 1'b1;
                    end else begin
                        cnt_n = cnt + 4'd1;
                    end
                end
                PRESSED: if (!s) begin
                    st_n  = RELEASE_WAIT;
                    cnt_n = 4'd1;
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        st_n  = PRESSED;
                        cnt_n = '0;
                    end else if (cnt + 4'd1 == STABLE) begin
                        st_n    = IDLE;
                        cnt_n   = '0;
                        lvl_n   = 1'b0;
                        rls_nxt = 1'b1;
                    end else begin
                        cnt_n = cnt + 4'd1;
                    end
                end
                default: begin
                    st_n  = IDLE;
                    cnt_n = '0;
                end
            endcase
        end
    end

`ifdef LONG_PRESS_EN
    localparam logic [7:0] LONG_T = 8'(LONG_TICKS);

    logic [7:0] hold;
    logic       held, lng_nxt;

    assign held    = (st == PRESSED) || (st == RELEASE_WAIT);
    assign lng_nxt = tick && held && (hold != LONG_T) && (hold + 8'd1 == LONG_T);

    // Hold counter: restarts on a fresh press (a release bounce back into
    // PRESSED continues the same press), saturates so the pulse fires once.
    always_ff @(posedge clk) begin
        if (clr) begin
            hold <= '0;
            lng  <= 1'b0;
        end else begin
            lng <= lng_nxt;
            if (tick && st == PRESS_WAIT && st_n == PRESSED)
                hold <= '0;
            else if (tick && held && hold != LONG_T)
                hold <= hold + 8'd1;
        end
    end
`else
    assign lng = 1'b0;
`endif
endmodule

// Top: shared divider/tick, lane array and press priority encoder.
module debounce_ctrl #(
    parameter int N_BTN      = 5,
    parameter int TICK_BITS  = 19,
    parameter int STABLE_CNT = 3,
    parameter int LONG_TICKS = 64
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long,
    output logic             press_valid,
    output logic [3:0]       press_code,
    output logic             tick
);
    logic [TICK_BITS-1:0] div;
    logic [N_BTN-1:0]     press_nxt;
    logic [3:0]           code_n;

    // Free-running divider; tick is registered so it lands one cycle after all-ones.
    always_ff @(posedge clk) begin
        if (clr) begin
            div  <= '0;
            tick <= 1'b0;
        end else begin
            div  <= div + TICK_BITS'(1);
            tick <= &div;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_lane
        debounce_lane #(
            .STABLE_CNT (STABLE_CNT)
`ifdef LONG_PRESS_EN
            , .LONG_TICKS (LONG_TICKS)
`endif
        ) u_lane (
            .clk       (clk),
            .clr       (clr),
            .tick      (tick),
            .raw       (btn_in[g]),
            .level     (btn_level[g]),
            .press     (btn_press[g]),
            .press_nxt (press_nxt[g]),
            .rls       (btn_release[g]),
            .lng       (btn_long[g])
        );
    end

    // Lowest-numbered pressing channel wins; 0 when nothing is pressed.
    always_comb begin
        code_n = '0;
        for (int i = N_BTN - 1; i >= 0; i--)
            if (press_nxt[i]) code_n = 4'(i);
    end

    // Register the press summary alongside the per-channel press pulses.
    always_ff @(posedge clk) begin
        if (clr) begin
            press_valid <= 1'b0;
            press_code  <= '0;
        end else begin
            press_valid <= |press_nxt;
            press_code  <= code_n;
        end
    end
endmodule

// File: tb/tb_debounce_ctrl.sv
// Directed bench for debounce_ctrl: TICK_BITS=4, STABLE_CNT=3, N_BTN=3,
// LONG_TICKS=8. Long-press expectations follow LONG_PRESS_EN.
module tb_debounce_ctrl;
    logic       clk = 1'b0;
    logic       clr;
    logic [2:0] btn_in;
    logic [2:0] btn_level, btn_press, btn_release, btn_long;
    logic       press_valid, tick;
    logic [3:0] press_code;

    int checks = 0;
    int errors = 0;

    debounce_ctrl #(
        .N_BTN(3), .TICK_BITS(4), .STABLE_CNT(3), .LONG_TICKS(8)
    ) dut (
        .clk(clk), .clr(clr), .btn_in(btn_in),
        .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .btn_long(btn_long),
        .press_valid(press_valid), .press_code(press_code), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Step until tick is high in the current cycle, bounded.
    task automatic wait_tick(output int n);
        n = 0;
        while (tick !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (tick !== 1'b1) begin
            errors++;
            $display("FAIL wait_tick: tick not seen within %0d cycles", n);
        end
    endtask

    // Let the FSMs consume the next tick; outputs then show that edge.
    task automatic adv_tick;
        int n;
        wait_tick(n);
        step();
    endtask

    task automatic test_reset;
        logic exp;
        clr = 1'b1;
        btn_in = '0;
        repeat (3) step();
        clr = 1'b0;
        checks++;
        if ({btn_level, btn_press, btn_release, btn_long, press_valid, press_code, tick} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {btn_level, btn_press, btn_release, btn_long, press_valid, press_code, tick});
        end
        for (int k = 1; k <= 32; k++) begin
            step();
            exp = (k == 16 || k == 32);
            checks++;
            if (tick !== exp) begin
                errors++;
                $display("FAIL tick_period cycle %0d: got %b expected %b", k, tick, exp);
            end
        end
    endtask

    task automatic test_clean_press;
        logic [2:0] el, ep, er;
        adv_tick();
        btn_in[1] = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            adv_tick();
            el = (t == 3) ? 3'b010 : 3'b000;
            checks++;
            if ({btn_level, btn_press, press_valid, press_code} !== {el, el, (t == 3), (t == 3) ? 4'd1 : 4'd0}) begin
                errors++;
                $display("FAIL clean_press tick %0d: got lvl=%b prs=%b v=%b code=%0d expected lvl=%b prs=%b",
                         t, btn_level, btn_press, press_valid, press_code, el, el);
            end
        end
        step();
        checks++;
        if ({btn_level, btn_press, press_valid} !== {3'b010, 3'b000, 1'b0}) begin
            errors++;
            $display("FAIL press_one_cycle: got lvl=%b prs=%b v=%b expected lvl=010 prs=000 v=0",
                     btn_level, btn_press, press_valid);
        end
        btn_in[1] = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            adv_tick();
            el = (t == 3) ? 3'b000 : 3'b010;
            er = (t == 3) ? 3'b010 : 3'b000;
            ep = 3'b000;
            checks++;
            if ({btn_level, btn_release, btn_press} !== {el, er, ep}) begin
                errors++;
                $display("FAIL clean_release tick %0d: got lvl=%b rel=%b prs=%b expected lvl=%b rel=%b prs=000",
                         t, btn_level, btn_release, btn_press, el, er);
            end
        end
        step();
        checks++;
        if (btn_release !== 3'b000) begin
            errors++;
            $display("FAIL release_one_cycle: got %b expected 000", btn_release);
        end
    endtask

    task automatic test_glitch;
        btn_in[0] = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            if (t == 3) btn_in[0] = 1'b0;
            adv_tick();
            checks++;
            if ({btn_level, btn_press, press_valid} !== 7'd0) begin
                errors++;
                $display("FAIL glitch tick %0d: got lvl=%b prs=%b v=%b expected all zero",
                         t, btn_level, btn_press, press_valid);
            end
        end
        // A fresh press must again need three full ticks (FSM restarted from IDLE).
        btn_in[0] = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            adv_tick();
            checks++;
            if ({btn_press, press_valid, press_code} !== ((t == 3) ? {3'b001, 1'b1, 4'd0} : 8'd0)) begin
                errors++;
                $display("FAIL glitch_recover tick %0d: got prs=%b v=%b code=%0d", t, btn_press, press_valid, press_code);
            end
        end
        btn_in[0] = 1'b0;
        repeat (3) adv_tick();
        checks++;
        if ({btn_level, btn_release} !== {3'b000, 3'b001}) begin
            errors++;
            $display("FAIL glitch_release: got lvl=%b rel=%b expected lvl=000 rel=001", btn_level, btn_release);
        end
    endtask

    task automatic test_simultaneous;
        step();
        btn_in = 3'b110;
        for (int t = 1; t <= 3; t++) begin
            adv_tick();
            checks++;
            if ({btn_press, press_valid, press_code} !== ((t == 3) ? {3'b110, 1'b1, 4'd1} : 8'd0)) begin
                errors++;
                $display("FAIL simultaneous tick %0d: got prs=%b v=%b code=%0d expected prs=110 v=1 code=1 on tick 3",
                         t, btn_press, press_valid, press_code);
            end
        end
        btn_in = 3'b000;
        repeat (3) adv_tick();
        checks++;
        if ({btn_level, btn_release} !== {3'b000, 3'b110}) begin
            errors++;
            $display("FAIL simultaneous_release: got lvl=%b rel=%b expected lvl=000 rel=110", btn_level, btn_release);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        step();
        btn_in[2] = 1'b1;
        repeat (2) adv_tick();
        clr = 1'b1;
        step();
        checks++;
        if ({btn_level, btn_press, btn_release, press_valid, tick} !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got lvl=%b prs=%b rel=%b v=%b tick=%b expected all zero",
                     btn_level, btn_press, btn_release, press_valid, tick);
        end
        step();
        clr = 1'b0;
        wait_tick(n);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL reset_mid_first_tick: got %0d cycles expected 16", n);
        end
        step();
        for (int t = 1; t <= 3; t++) begin
            if (t > 1) adv_tick();
            checks++;
            if ({btn_level, btn_press, press_valid, press_code} !==
                ((t == 3) ? {3'b100, 3'b100, 1'b1, 4'd2} : 11'd0)) begin
                errors++;
                $display("FAIL reset_mid_restart tick %0d: got lvl=%b prs=%b v=%b code=%0d",
                         t, btn_level, btn_press, press_valid, press_code);
            end
        end
        btn_in[2] = 1'b0;
        repeat (3) adv_tick();
        checks++;
        if ({btn_level, btn_release} !== {3'b000, 3'b100}) begin
            errors++;
            $display("FAIL reset_mid_release: got lvl=%b rel=%b expected lvl=000 rel=100", btn_level, btn_release);
        end
    endtask

    task automatic test_long_press;
        logic [2:0] el;
        step();
        btn_in[0] = 1'b1;
        repeat (3) adv_tick();
        checks++;
        if ({btn_press, btn_long} !== {3'b001, 3'b000}) begin
            errors++;
            $display("FAIL long_entry: got prs=%b long=%b expected prs=001 long=000", btn_press, btn_long);
        end
        for (int t = 1; t <= 12; t++) begin
            adv_tick();
`ifdef LONG_PRESS_EN
            el = (t == 8) ? 3'b001 : 3'b000;
`else
            el = 3'b000;
`endif
            checks++;
            if (btn_long !== el) begin
                errors++;
                $display("FAIL long_pulse tick %0d: got %b expected %b", t, btn_long, el);
            end
            step();
            checks++;
            if (btn_long !== 3'b000) begin
                errors++;
                $display("FAIL long_one_cycle tick %0d: got %b expected 000", t, btn_long);
            end
        end
        btn_in[0] = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            adv_tick();
            checks++;
            if ({btn_long, btn_release} !== {3'b000, (t == 3) ? 3'b001 : 3'b000}) begin
                errors++;
                $display("FAIL long_release tick %0d: got long=%b rel=%b", t, btn_long, btn_release);
            end
        end
    endtask

    initial begin
        clr = 1'b1;
        btn_in = '0;
        test_reset();
        test_clean_press();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        test_long_press();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/debounce_ctrl.md
Name: debounce_ctrl

Overview:
- Multi-channel push-button debounce controller built around one shared slow sample tick.
- Owns the free-running divider counter and produces a one-cycle tick enable instead of a derived clock.
- Sequences a per-channel debounce FSM on each tick, then emits clean levels, press/release pulses and a priority-encoded press event for downstream control logic (mode select, single-step).
- Sits between the board pushbuttons and the CPU/IO control logic; everything runs on the single system clock.

Parameters:
N_BTN, 5, number of button channels (1..16)
TICK_BITS, 19, divider width; tick period = 2^TICK_BITS clk cycles
STABLE_CNT, 3, consecutive ticks of stable input required to change state (2..15)
LONG_TICKS, 64, ticks held in PRESSED before long-press pulse (used only with LONG_PRESS_EN; 2..255)

Ports:
clk  input  1  system clock, all logic on posedge
clr  input  1  synchronous, active-high reset
btn_in  input  N_BTN  raw asynchronous button inputs, active-high
btn_level  output  N_BTN  debounced level per channel
btn_press  output  N_BTN  one-cycle pulse on debounced 0->1
btn_release  output  N_BTN  one-cycle pulse on debounced 1->0
btn_long  output  N_BTN  one-cycle long-press pulse (constant 0 without LONG_PRESS_EN)
press_valid  output  1  one-cycle pulse: at least one btn_press bit set this cycle
press_code  output  4  index of lowest-numbered channel with btn_press set; valid with press_valid
tick  output  1  one-cycle sample enable, exported for other slow logic

Behaviour:
- Reset: clr sampled on posedge only (synchronous). While clr=1, at each edge: divider=0, synchronizers=0, all FSMs=IDLE, all per-channel counters=0. All outputs 0, press_code=0. Reset mid-debounce discards partial counts; no pulses are emitted for the abandoned transition.
- Divider: TICK_BITS-bit counter, +1 every cycle, wraps naturally. tick=1 (registered) for exactly one cycle when counter == all ones; after clr deasserts, the first tick is high in cycle 2^TICK_BITS.
- Synchronizer: two flops per channel. s = second stage. Raw-to-s latency is 2 cycles.
- Per-channel FSM; advances only in cycles where tick=1, otherwise holds state and count:
  - IDLE (level 0): s=1 -> PRESS_WAIT, cnt=1; s=0 -> stay.
  - PRESS_WAIT: s=1 and cnt+1==STABLE_CNT -> PRESSED, cnt=0, btn_press=1 next cycle; s=1 otherwise -> cnt+1; s=0 -> IDLE, cnt=0 (glitch rejected, no pulse).
  - PRESSED (level 1): s=0 -> RELEASE_WAIT, cnt=1; s=1 -> stay.
  - RELEASE_WAIT (level 1): s=0 and cnt+1==STABLE_CNT -> IDLE, btn_release=1 next cycle; s=0 otherwise -> cnt+1; s=1 -> PRESSED, cnt=0.
- btn_level is registered and updates on the same edge the FSM enters PRESSED/IDLE. btn_press/btn_release are high in exactly the cycle after that tick, then cleared.
- Press latency from a stable input: STABLE_CNT ticks, with the first tick falling at least 2 cycles after the input edge.
- Channels are independent; simultaneous presses pulse in the same cycle. press_valid = OR of btn_press. press_code = lowest set index (channel 0 has highest priority), registered alongside btn_press.
- cnt width is 4 bits; STABLE_CNT outside 2..15 is unsupported.

Optional Feature:
LONG_PRESS_EN
- Defined: per-channel 8-bit hold counter, cleared on entry to PRESSED and incremented on each tick while in PRESSED or RELEASE_WAIT. When it reaches LONG_TICKS, btn_long pulses one cycle, and counter saturates so it fires once per press. clr clears it.
- Undefined: no hold counters are synthesized; btn_long is tied to 0.

Test Plan:
(Bench parameters for all scenarios: TICK_BITS=4 (tick every 16 cycles), STABLE_CNT=3, N_BTN=3, LONG_TICKS=8.)
- Reset: hold clr 3 cycles, then release -> all outputs 0; tick first high in cycle 16, then every 16 cycles.
- Clean press on btn_in[1] held high -> btn_level[1] rises on the 3rd tick edge; btn_press[1] and press_valid high 1 cycle after it, press_code=1. Release held -> btn_release[1] after 3 ticks, btn_level[1]=0.
- Glitch: btn_in[0] high across 2 ticks, then low before the 3rd -> no btn_press, btn_level[0] stays 0, FSM back in IDLE.
- Simultaneous: btn_in[2] and btn_in[1] rise the same cycle -> btn_press=3'b110 in one cycle, press_code=1.
- Reset mid-debounce: clr asserted in PRESS_WAIT after 2 ticks -> no pulses; after clr, input still high needs a full 3 ticks from the restarted divider.
- LONG_PRESS_EN defined, btn_in[0] held -> btn_long[0] single pulse 8 ticks after PRESSED entry, no repeat. Undefined -> btn_long stays 0.
